// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one ALU between the execute stage (port 0)
// and the branch/address unit (port 1), returning results through a one-entry buffer.

module alu (
    input  logic [4:0]  fn_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        result_eq_zero_o
);
    // Function codes match the ALU_* values used by the decoder.
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    always_comb begin
        result_o = '0;
        case (fn_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'b0, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

    assign result_eq_zero_o = (result_o == '0);
endmodule

module alu_arbiter #(
    parameter int PIPE_THROUGH = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_fn,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_fn,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_eq_zero
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] result_q, result_d;
    logic        eqz_q, eqz_d;

    logic        owner_rdy, can_accept, winner, accept;
    logic [4:0]  alu_fn;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_eqz;

    assign owner_rdy  = owner_q ? rsp1_ready : rsp0_ready;
    assign can_accept = !reset && ((state_q == IDLE) ||
                        ((PIPE_THROUGH != 0) && (state_q == HOLD) && owner_rdy));

    // On a tie the requester that did not win last time goes first.
    assign winner     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = can_accept && req0_valid && !winner;
    assign req1_ready = can_accept && req1_valid && winner;
    assign accept     = req0_ready || req1_ready;

    assign alu_fn = winner ? req1_fn : req0_fn;
    assign alu_a  = winner ? req1_a  : req0_a;
    assign alu_b  = winner ? req1_b  : req0_b;

    alu u_alu (
        .fn_i             (alu_fn),
        .a_i              (alu_a),
        .b_i              (alu_b),
        .result_o         (alu_res),
        .result_eq_zero_o (alu_eqz)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HOLD;
            HOLD:    if (!accept && owner_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp0_valid = (state_q == HOLD) && !owner_q;
        rsp1_valid = (state_q == HOLD) && owner_q;
    end

    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        result_d = result_q;
        eqz_d    = eqz_q;
        if (accept) begin
            owner_d  = winner;
            last_d   = winner;
            result_d = alu_res;
            eqz_d    = alu_eqz;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            eqz_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            last_q   <= last_d;
            result_q <= result_d;
            eqz_q    <= eqz_d;
        end
    end

    assign rsp_result  = result_q;
    assign rsp_eq_zero = eqz_q;
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one alu instance between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. Each requester issues an operation with a valid/ready handshake. A round-robin arbiter grants one request per cycle. The alu output is captured in a one-entry response register and returned to the winning requester with a valid/ready handshake. The block sits between the decode/issue logic and the shared alu and instantiates that alu internally.

Parameters:
PIPE_THROUGH, 1, when 1 a new request can be granted in the same cycle the held response drains; when 0 one idle cycle separates a drain from the next grant.

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_fn  input  5  ALU function code (ALU_* from constants.svh)
req0_a  input  32  operand A
req0_b  input  32  operand B
rsp0_valid  output  1  response for requester 0 available
rsp0_ready  input  1  requester 0 consumes response
req1_valid, req1_ready, req1_fn, req1_a, req1_b  same as port 0, for requester 1
rsp1_valid  output  1  response for requester 1 available
rsp1_ready  input  1  requester 1 consumes response
rsp_result  output  32  held ALU result; shared by both ports and meaningful only with the matching rspN_valid
rsp_eq_zero  output  1  held result_eq_zero flag

Behaviour:
- States: IDLE (response register empty) and HOLD (response register full; owner bit selects 0 or 1).
- Reset values: state=IDLE, owner=0, last_grant=1 (requester 0 wins the first tie), rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_eq_zero=0, req0_ready=req1_ready=0.
- can_accept = (state==IDLE) | (PIPE_THROUGH & state==HOLD & rsp_ready of owner).
- Grant, which is combinational:
  - With only one requester valid, that requester wins.
  - With both valid, the requester that is not last_grant wins.
  - reqN_ready = can_accept & (winner==N). At most one ready is high per cycle, and ready never asserts without the matching valid.
- The alu operands and function are muxed from the winner. A handshake (valid & ready) latches the alu result and result_eq_zero into the response register, sets owner=N and last_grant=N, and enters HOLD. Latency is exactly 1 cycle from accept to rspN_valid.
- rspN_valid = (state==HOLD) & (owner==N). rsp_result and rsp_eq_zero are stable while in HOLD.
- Drain: in HOLD with the owner's rsp_ready high, the response is consumed. With a simultaneous new grant the block stays in HOLD and takes the new owner and data; otherwise it returns to IDLE.
- rsp_ready of the non-owner is ignored. Requester inputs are not sampled unless ready is high, so a requester must hold valid, fn and operands stable until accepted.
- Undefined function codes pass through the alu default, giving result 0 and eq_zero 1. No error is flagged.
- Fairness: with both requesters continuously valid and responses drained immediately, grants alternate 0,1,0,1. A requester waits at most one grant behind the other.
- Reset asserted mid-HOLD discards the held response. Both rsp_valid outputs are low in the cycle after reset.
- Throughput with PIPE_THROUGH=1 is one operation per cycle. With PIPE_THROUGH=0 it is at most one operation every two cycles.

Test Plan:
- Single op: req0 ADD a=5 b=7 accepted at cycle t -> rsp0_valid=1 at t+1, rsp_result=12, rsp_eq_zero=0, rsp1_valid=0.
- Contention after reset: req0 SUB 9-9 and req1 SLTU 1<2 valid together, both rsp_ready high -> req0 granted first (result 0, eq_zero 1), req1 next cycle (result 1). Sustained contention gives alternating grants over 8 cycles.
- Backpressure: rsp1_ready held low for 3 cycles with req0 pending -> req0_ready stays 0 and rsp_result is stable. When rsp1_ready rises, req0 is granted that same cycle (PIPE_THROUGH=1) and rsp0_valid follows next cycle.
- PIPE_THROUGH=0: back-to-back req0 XOR ops with rsp0_ready always 1 -> accepts occur every other cycle only.
- Reset mid-HOLD: accept SRA 0x80000000>>>4, assert reset before drain -> rsp0_valid=0 next cycle. The first post-reset tie goes to requester 0.
- Undefined fn 5'h1F from req1 -> rsp_result=0, rsp_eq_zero=1, handshake completes normally.
